branch_ctrl: RTL and testbench

Sequencing controller for the shared branch comparator in the execute stage. It accepts one conditional-branch request at a time over a valid/ready handshake and drives the comparator's operands and signed/unsigned select. It captures the less/equal flags, resolves taken/not-taken and the target against the front-end prediction, then returns a result and sequences a pipeline flush on mispredict. It also keeps saturating branch and mispredict counters.

---
 rtl/branch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequencing controller for the shared execute-stage branch
// comparator. Accepts one conditional branch at a time, drives the
// comparator operands, captures its flags, resolves taken/target against
// the front-end prediction, returns the result and strobes a flush on
// mispredict. Keeps saturating branch / mispredict counters.
//
// Ports:
//   clk_i, rst_ni               clock (rising edge), async active-low reset
//   br_valid_i / br_ready_o     request handshake
//   br_funct3_i, br_pc_i, br_imm_i, br_rs1_i, br_rs2_i, br_pred_taken_i
//                               request payload
//   cmp_rs1_o, cmp_rs2_o, cmp_unsigned_o   registered comparator drive
//   cmp_less_i, cmp_equal_i     comparator flags (combinational from cmp_*)
//   res_valid_o / res_ready_i   result handshake
//   res_taken_o, res_next_pc_o, res_mispred_o, res_illegal_o   result
//   flush_o                     pipeline flush strobe
//   kill_i                      synchronous abort of the in-flight branch
//   br_count_o, mispred_count_o saturating statistics
module branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [2:0]       br_funct3_i,
  input  logic [31:0]      br_pc_i,
  input  logic [31:0]      br_imm_i,
  input  logic [31:0]      br_rs1_i,
  input  logic [31:0]      br_rs2_i,
  input  logic             br_pred_taken_i,
  output logic [31:0]      cmp_rs1_o,
  output logic [31:0]      cmp_rs2_o,
  output logic             cmp_unsigned_o,
  input  logic             cmp_less_i,
  input  logic             cmp_equal_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_taken_o,
  output logic [31:0]      res_next_pc_o,
  output logic             res_mispred_o,
  output logic             res_illegal_o,
  output logic             flush_o,
  input  logic             kill_i,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, RESOLVE = 2'd2, FLUSH = 2'd3} state_e;

  state_e           state_q, state_d;
  logic [2:0]       funct3_q;
  logic [31:0]      pc_q, imm_q;
  logic             pred_q;
  logic [31:0]      cmp_rs1_q, cmp_rs2_q;
  logic             cmp_unsigned_q;
  logic             res_valid_q, res_taken_q, res_mispred_q, res_illegal_q;
  logic [31:0]      res_next_pc_q;
  logic [3:0]       flush_cnt_q;
  logic [CNT_W-1:0] br_cnt_q, mp_cnt_q;

  logic             accept, handshake;
  logic             dec_taken, dec_illegal;
  logic [31:0]      dec_next_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // kill_i blocks acceptance in IDLE and wins over a same-cycle result handshake
  assign accept    = (state_q == IDLE) && br_valid_i && !kill_i;
  assign handshake = (state_q == RESOLVE) && res_valid_q && res_ready_i && !kill_i;

  // Branch decision from the comparator flags; illegal encodings resolve not-taken
  always_comb begin
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    case (funct3_q)
      3'b000:          dec_taken = cmp_equal_i;
      3'b001:          dec_taken = !cmp_equal_i;
      3'b100, 3'b110:  dec_taken = cmp_less_i;
      3'b101, 3'b111:  dec_taken = !cmp_less_i;
      default:         dec_illegal = 1'b1;
    endcase
    dec_next_pc = dec_taken ? (pc_q + imm_q) : (pc_q + 32'd4);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    state_d = kill_i ? IDLE : RESOLVE;
      RESOLVE: begin
        if (kill_i)         state_d = IDLE;
        else if (handshake) state_d = res_mispred_q ? FLUSH : IDLE;
      end
      FLUSH:   if (flush_cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    br_ready_o = (state_q == IDLE);
    flush_o    = (state_q == FLUSH);
  end

  // Datapath, result and statistics registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funct3_q       <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      pred_q         <= 1'b0;
      cmp_rs1_q      <= '0;
      cmp_rs2_q      <= '0;
      cmp_unsigned_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_taken_q    <= 1'b0;
      res_mispred_q  <= 1'b0;
      res_illegal_q  <= 1'b0;
      res_next_pc_q  <= '0;
      flush_cnt_q    <= '0;
      br_cnt_q       <= '0;
      mp_cnt_q       <= '0;
    end else begin
      if (accept) begin
        funct3_q       <= br_funct3_i;
        pc_q           <= br_pc_i;
        imm_q          <= br_imm_i;
        pred_q         <= br_pred_taken_i;
        cmp_rs1_q      <= br_rs1_i;
        cmp_rs2_q      <= br_rs2_i;
        cmp_unsigned_q <= br_funct3_i[1];
      end
      if (state_q == EVAL && !kill_i) begin
        res_taken_q   <= dec_taken;
        res_illegal_q <= dec_illegal;
        res_next_pc_q <= dec_next_pc;
        res_mispred_q <= dec_taken != pred_q;
      end
      // Valid is registered: it rises one cycle into RESOLVE, so results
      // appear two edges after acceptance, and drops after handshake or kill.
      res_valid_q <= (state_q == RESOLVE) && !kill_i && !handshake;
      if (handshake) begin
        br_cnt_q <= sat_inc(br_cnt_q);
        if (res_mispred_q) mp_cnt_q <= sat_inc(mp_cnt_q);
      end
      // Loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles
      if (handshake && res_mispred_q)
        flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
      else if (state_q == FLUSH && flush_cnt_q != 4'd0)
        flush_cnt_q <= flush_cnt_q - 4'd1;
    end
  end

  assign cmp_rs1_o       = cmp_rs1_q;
  assign cmp_rs2_o       = cmp_rs2_q;
  assign cmp_unsigned_o  = cmp_unsigned_q;
  assign res_valid_o     = res_valid_q;
  assign res_taken_o     = res_taken_q;
  assign res_next_pc_o   = res_next_pc_q;
  assign res_mispred_o   = res_mispred_q;
  assign res_illegal_o   = res_illegal_q;
  assign br_count_o      = br_cnt_q;
  assign mispred_count_o = mp_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance (defaults: FLUSH_CYCLES=2, CNT_W=16)
  logic        rst_n, br_valid, br_ready, br_pred, cmp_uns, cmp_less, cmp_eq;
  logic        res_valid, res_ready, res_taken, res_mispred, res_illegal, flush, kill;
  logic [2:0]  br_f3;
  logic [31:0] br_pc, br_imm, br_rs1, br_rs2, cmp_a, cmp_b, res_npc;
  logic [15:0] br_cnt, mp_cnt;

  // Comparator model driven from the registered operands
  always_comb begin
    cmp_eq   = (cmp_a == cmp_b);
    cmp_less = cmp_uns ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));
  end

  branch_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .br_valid_i(br_valid), .br_ready_o(br_ready),
    .br_funct3_i(br_f3), .br_pc_i(br_pc), .br_imm_i(br_imm), .br_rs1_i(br_rs1),
    .br_rs2_i(br_rs2), .br_pred_taken_i(br_pred), .cmp_rs1_o(cmp_a), .cmp_rs2_o(cmp_b),
    .cmp_unsigned_o(cmp_uns), .cmp_less_i(cmp_less), .cmp_equal_i(cmp_eq),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_taken_o(res_taken),
    .res_next_pc_o(res_npc), .res_mispred_o(res_mispred), .res_illegal_o(res_illegal),
    .flush_o(flush), .kill_i(kill), .br_count_o(br_cnt), .mispred_count_o(mp_cnt)
  );

  // Small-counter instance for saturation (FLUSH_CYCLES=3, CNT_W=2)
  logic        s_valid, s_ready_o, s_pred, s_uns, s_less, s_eq;
  logic        s_res_valid, s_res_ready, s_taken, s_mispred, s_illegal, s_flush;
  logic [2:0]  s_f3;
  logic [31:0] s_pc, s_imm, s_rs1, s_rs2, s_a, s_b, s_npc;
  logic [1:0]  s_bcnt, s_mcnt;

  always_comb begin
    s_eq   = (s_a == s_b);
    s_less = s_uns ? (s_a < s_b) : ($signed(s_a) < $signed(s_b));
  end

  branch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .br_valid_i(s_valid), .br_ready_o(s_ready_o),
    .br_funct3_i(s_f3), .br_pc_i(s_pc), .br_imm_i(s_imm), .br_rs1_i(s_rs1),
    .br_rs2_i(s_rs2), .br_pred_taken_i(s_pred), .cmp_rs1_o(s_a), .cmp_rs2_o(s_b),
    .cmp_unsigned_o(s_uns), .cmp_less_i(s_less), .cmp_equal_i(s_eq),
    .res_valid_o(s_res_valid), .res_ready_i(s_res_ready), .res_taken_o(s_taken),
    .res_next_pc_o(s_npc), .res_mispred_o(s_mispred), .res_illegal_o(s_illegal),
    .flush_o(s_flush), .kill_i(1'b0), .br_count_o(s_bcnt), .mispred_count_o(s_mcnt)
  );

  // Present a request at the current negedge; returns at the next negedge (DUT in EVAL)
  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic pred);
    br_f3 = f3; br_pc = pc; br_imm = imm; br_rs1 = a; br_rs2 = b; br_pred = pred;
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", br_ready); end
    checks++; if ({res_valid, res_taken, res_mispred, res_illegal, flush, cmp_uns} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {res_valid, res_taken, res_mispred, res_illegal, flush, cmp_uns}); end
    checks++; if ({cmp_a, cmp_b, res_npc, br_cnt, mp_cnt} !== '0) begin failures++; $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0", cmp_a, cmp_b, res_npc, br_cnt, mp_cnt); end
  endtask

  task automatic test_blt_mispred();
    issue(3'b100, 32'h0000_1000, 32'h0000_0020, 32'hFFFF_FFFF, 32'h1, 1'b0);
    checks++; if (cmp_uns !== 1'b0) begin failures++; $display("FAIL blt_unsigned got=%b exp=0", cmp_uns); end
    checks++; if (cmp_a !== 32'hFFFF_FFFF || cmp_b !== 32'h1) begin failures++; $display("FAIL blt_operands got=%h/%h exp=ffffffff/1", cmp_a, cmp_b); end
    checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL blt_ready_eval got=%b exp=0", br_ready); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL blt_valid_early got=%b exp=0", res_valid); end
    @(negedge clk);
    checks++; if ({res_valid, res_taken, res_mispred, res_illegal} !== 4'b1110) begin failures++; $display("FAIL blt_result got=%b exp=1110", {res_valid, res_taken, res_mispred, res_illegal}); end
    checks++; if (res_npc !== 32'h0000_1020) begin failures++; $display("FAIL blt_next_pc got=%h exp=00001020", res_npc); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL blt_flush1 got=v%b f%b exp=v0 f1", res_valid, flush); end
    checks++; if (br_cnt !== 16'd1 || mp_cnt !== 16'd1) begin failures++; $display("FAIL blt_counts got=%0d/%0d exp=1/1", br_cnt, mp_cnt); end
    @(negedge clk);
    checks++; if (flush !== 1'b1 || br_ready !== 1'b0) begin failures++; $display("FAIL blt_flush2 got=f%b r%b exp=f1 r0", flush, br_ready); end
    @(negedge clk);
    checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin failures++; $display("FAIL blt_flush_end got=f%b r%b exp=f0 r1", flush, br_ready); end
  endtask

  task automatic test_bltu();
    issue(3'b110, 32'h0000_2000, 32'h0000_0040, 32'hFFFF_FFFF, 32'h1, 1'b0);
    checks++; if (cmp_uns !== 1'b1) begin failures++; $display("FAIL bltu_unsigned got=%b exp=1", cmp_uns); end
    repeat (2) @(negedge clk);
    checks++; if ({res_valid, res_taken, res_mispred} !== 3'b100 || res_npc !== 32'h0000_2004) begin failures++; $display("FAIL bltu_result got=%b pc=%h exp=100 pc=00002004", {res_valid, res_taken, res_mispred}, res_npc); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin failures++; $display("FAIL bltu_noflush got=f%b r%b exp=f0 r1", flush, br_ready); end
    checks++; if (br_cnt !== 16'd2 || mp_cnt !== 16'd1) begin failures++; $display("FAIL bltu_counts got=%0d/%0d exp=2/1", br_cnt, mp_cnt); end
  endtask

  task automatic test_beq_hold();
    issue(3'b000, 32'h0000_0100, 32'hFFFF_FFF0, 32'd5, 32'd5, 1'b1);
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL beq_valid_early got=%b exp=0", res_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({res_valid, res_taken, res_mispred, br_ready} !== 4'b1100 || res_npc !== 32'h0000_00F0) begin failures++; $display("FAIL beq_hold%0d got=%b pc=%h exp=1100 pc=000000f0", i, {res_valid, res_taken, res_mispred, br_ready}, res_npc); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || br_cnt !== 16'd3 || mp_cnt !== 16'd1) begin failures++; $display("FAIL beq_done got=v%b %0d/%0d exp=v0 3/1", res_valid, br_cnt, mp_cnt); end
  endtask

  task automatic test_illegal();
    issue(3'b010, 32'h0000_0500, 32'h0000_0100, 32'd1, 32'd1, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if ({res_valid, res_illegal, res_taken, res_mispred} !== 4'b1101 || res_npc !== 32'h0000_0504) begin failures++; $display("FAIL illegal_result got=%b pc=%h exp=1101 pc=00000504", {res_valid, res_illegal, res_taken, res_mispred}, res_npc); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (flush !== 1'b1 || br_cnt !== 16'd4 || mp_cnt !== 16'd2) begin failures++; $display("FAIL illegal_flush got=f%b %0d/%0d exp=f1 4/2", flush, br_cnt, mp_cnt); end
    repeat (2) @(negedge clk);
    checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin failures++; $display("FAIL illegal_flush_end got=f%b r%b exp=f0 r1", flush, br_ready); end
  endtask

  task automatic test_kill_resolve();
    issue(3'b000, 32'h0000_0600, 32'h0000_0010, 32'd7, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_mispred !== 1'b1) begin failures++; $display("FAIL kill_pre got=v%b m%b exp=v1 m1", res_valid, res_mispred); end
    res_ready = 1'b1; kill = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; kill = 1'b0;
    checks++; if ({res_valid, flush, br_ready} !== 3'b001 || br_cnt !== 16'd4 || mp_cnt !== 16'd2) begin failures++; $display("FAIL kill_resolve got=%b %0d/%0d exp=001 4/2", {res_valid, flush, br_ready}, br_cnt, mp_cnt); end
    @(negedge clk);
    checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin failures++; $display("FAIL kill_after got=f%b r%b exp=f0 r1", flush, br_ready); end
  endtask

  task automatic test_kill_idle();
    br_f3 = 3'b000; br_rs1 = 32'hA5; br_rs2 = 32'hA5; br_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    br_valid = 1'b0; kill = 1'b0;
    checks++; if (br_ready !== 1'b1 || cmp_a === 32'hA5) begin failures++; $display("FAIL kill_idle got=r%b a=%h exp=r1 not a5", br_ready, cmp_a); end
  endtask

  task automatic test_back_to_back();
    issue(3'b001, 32'h0000_3000, 32'h0000_0010, 32'd1, 32'd2, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_npc !== 32'h0000_3010 || res_mispred !== 1'b0) begin failures++; $display("FAIL b2b_first got=v%b pc=%h m%b exp=v1 pc=00003010 m0", res_valid, res_npc, res_mispred); end
    res_ready = 1'b1;
    br_f3 = 3'b101; br_pc = 32'h0000_4000; br_imm = 32'h8; br_rs1 = 32'd3; br_rs2 = 32'd3; br_pred = 1'b1;
    br_valid = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (br_ready !== 1'b1 || cmp_a !== 32'd1 || res_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_same_cycle got=r%b a=%h v%b exp=r1 a=1 v0", br_ready, cmp_a, res_valid); end
    @(negedge clk);
    br_valid = 1'b0;
    checks++; if (br_ready !== 1'b0 || cmp_a !== 32'd3) begin failures++; $display("FAIL b2b_accept got=r%b a=%h exp=r0 a=3", br_ready, cmp_a); end
    repeat (2) @(negedge clk);
    checks++; if ({res_valid, res_taken, res_mispred} !== 3'b110 || res_npc !== 32'h0000_4008) begin failures++; $display("FAIL b2b_second got=%b pc=%h exp=110 pc=00004008", {res_valid, res_taken, res_mispred}, res_npc); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (br_cnt !== 16'd6 || mp_cnt !== 16'd2) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=6/2", br_cnt, mp_cnt); end
  endtask

  task automatic test_wrap();
    issue(3'b001, 32'hFFFF_FFFC, 32'h0000_0008, 32'd1, 32'd2, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (res_npc !== 32'h0000_0004 || res_mispred !== 1'b0) begin failures++; $display("FAIL wrap_next_pc got=%h m%b exp=00000004 m0", res_npc, res_mispred); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 4; k++) begin
      s_f3 = 3'b000; s_pc = 32'h800; s_imm = 32'h4; s_rs1 = 32'd9; s_rs2 = 32'd9; s_pred = 1'b0;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (s_res_valid !== 1'b1 || s_mispred !== 1'b1) begin failures++; $display("FAIL sat_result%0d got=v%b m%b exp=v1 m1", k, s_res_valid, s_mispred); end
      s_res_ready = 1'b1;
      @(negedge clk);
      s_res_ready = 1'b0;
      checks++; if (s_bcnt !== 2'((k > 3) ? 3 : k) || s_mcnt !== 2'((k > 3) ? 3 : k)) begin failures++; $display("FAIL sat_counts%0d got=%0d/%0d exp=%0d/%0d", k, s_bcnt, s_mcnt, (k > 3) ? 3 : k, (k > 3) ? 3 : k); end
      for (int c = 0; c < 3; c++) begin
        if (c > 0) @(negedge clk);
        checks++; if (s_flush !== 1'b1) begin failures++; $display("FAIL sat_flush%0d_%0d got=%b exp=1", k, c, s_flush); end
      end
      @(negedge clk);
      checks++; if (s_flush !== 1'b0 || s_ready_o !== 1'b1) begin failures++; $display("FAIL sat_flush_end%0d got=f%b r%b exp=f0 r1", k, s_flush, s_ready_o); end
    end
  endtask

  task automatic test_async_reset();
    issue(3'b100, 32'h0000_9000, 32'h0000_0010, 32'h1234, 32'h5678, 1'b1);
    checks++; if (cmp_a !== 32'h1234 || br_ready !== 1'b0) begin failures++; $display("FAIL areset_pre got=a%h r%b exp=a1234 r0", cmp_a, br_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (br_ready !== 1'b1 || {res_valid, flush, cmp_uns, res_taken, res_mispred} !== 5'b0) begin failures++; $display("FAIL areset_ctrl got=r%b %b exp=r1 00000", br_ready, {res_valid, flush, cmp_uns, res_taken, res_mispred}); end
    checks++; if ({cmp_a, cmp_b, res_npc, br_cnt, mp_cnt} !== '0 || s_bcnt !== 2'd0) begin failures++; $display("FAIL areset_data got=%h/%h/%h/%h/%h/%h exp=0", cmp_a, cmp_b, res_npc, br_cnt, mp_cnt, s_bcnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; res_ready = 1'b0; kill = 1'b0;
    br_f3 = '0; br_pc = '0; br_imm = '0; br_rs1 = '0; br_rs2 = '0; br_pred = 1'b0;
    s_valid = 1'b0; s_res_ready = 1'b0; s_f3 = '0; s_pc = '0; s_imm = '0;
    s_rs1 = '0; s_rs2 = '0; s_pred = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_blt_mispred();
    test_bltu();
    test_beq_hold();
    test_illegal();
    test_kill_resolve();
    test_kill_idle();
    test_back_to_back();
    test_wrap();
    test_saturation();
    test_async_reset();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
